k3_weight_loader: RTL and testbench

- Write-side counterpart of the layer-3 kernel weight reader.
- Accepts a serial stream of 16-bit signed kernel weights from the host/DMA path and scatters them into the 36 per-bank kernel BRAMs (k3_1..k3_36, port B).
- Addresses use the same layout the reader walks: address = k_ind*36 + word offset.
- Sits between the parameter-load interface and the weight memories. It is active only during parameter loading, before convolution runs.

---
 rtl/k3_weight_loader_pkg.sv | 23 ++
 rtl/k3_weight_loader_walker.sv | 66 ++++++
 rtl/k3_weight_loader.sv | 101 ++++++++++
 tb/tb_k3_weight_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/k3_weight_loader_pkg.sv
// Shared constants, FSM encoding and bank-select helper for the layer-3 kernel weight loader.
package k3_weight_loader_pkg;

  localparam int NUM_BANKS        = 36;
  localparam int WORDS_PER_KERNEL = 36;
  localparam int DATA_W           = 16;
  localparam int ADDR_W           = 13;
  localparam int IND_W            = 7;
  localparam int CNT_W            = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [CNT_W-1:0] idx);
    logic [NUM_BANKS-1:0] v;
    v = {{(NUM_BANKS-1){1'b0}}, 1'b1};
    return v << idx;
  endfunction

endpackage

// File: rtl/k3_weight_loader_walker.sv
// Bank/word/kernel counters with an incrementally stepped kernel base address.
module k3_addr_walker
  import k3_weight_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init,
  input  logic [IND_W-1:0]  i_k_ind_start,
  input  logic [IND_W-1:0]  i_k_count,
  input  logic              i_advance,
  output logic [CNT_W-1:0]  o_bank,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [CNT_W-1:0]  r_bank;
  logic [CNT_W-1:0]  r_word;
  logic [IND_W-1:0]  r_kern;
  logic [IND_W-1:0]  r_kcount;
  logic [ADDR_W-1:0] r_base;

  logic              w_bank_wrap;
  logic              w_word_wrap;
  logic [ADDR_W-1:0] w_kind;
  logic [ADDR_W-1:0] w_base_init;

  assign w_bank_wrap = (r_bank == CNT_W'(NUM_BANKS - 1));
  assign w_word_wrap = (r_word == CNT_W'(WORDS_PER_KERNEL - 1));
  // k*36 as k*32 + k*4; only shifts and one adder at load start
  assign w_kind      = ADDR_W'(i_k_ind_start);
  assign w_base_init = (w_kind << 5) + (w_kind << 2);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bank   <= '0;
      r_word   <= '0;
      r_kern   <= '0;
      r_kcount <= '0;
      r_base   <= '0;
    end else if (i_init) begin
      r_bank   <= '0;
      r_word   <= '0;
      r_kern   <= '0;
      r_kcount <= i_k_count;
      r_base   <= w_base_init;
    end else if (i_advance) begin
      if (w_bank_wrap) begin
        r_bank <= '0;
        if (w_word_wrap) begin
          r_word <= '0;
          r_kern <= r_kern + IND_W'(1);
          r_base <= r_base + ADDR_W'(WORDS_PER_KERNEL);
        end else begin
          r_word <= r_word + CNT_W'(1);
        end
      end else begin
        r_bank <= r_bank + CNT_W'(1);
      end
    end
  end

  assign o_bank = r_bank;
  assign o_addr = r_base + ADDR_W'(r_word);
  assign o_last = w_bank_wrap & w_word_wrap & (r_kern == r_kcount);

endmodule

// File: rtl/k3_weight_loader.sv
// Scatters a serial weight stream into the 36 layer-3 kernel BRAMs through one registered write port.
//   state   | meaning
//   ST_IDLE | waiting for start; stream not accepted
//   ST_LOAD | accepting words, one write issued per accepted word
//   ST_DONE | final write on the bus, done pulse, back to idle
module k3_weight_loader
  import k3_weight_loader_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IND_W-1:0]     k_ind_start,
  input  logic [IND_W-1:0]     k_count,
  input  logic                 w_valid,
  input  logic [DATA_W-1:0]    w_data,
  output logic                 w_ready,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic                 busy,
  output logic                 done
);

  state_t r_state;
  state_t w_state_nxt;

  logic                 w_init;
  logic                 w_accept;
  logic                 w_last;
  logic [CNT_W-1:0]     w_bank;
  logic [ADDR_W-1:0]    w_addr;

  logic [NUM_BANKS-1:0] r_wr_en;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [DATA_W-1:0]    r_wr_data;

  k3_addr_walker u_walker (
    .i_clk         (clk_in),
    .i_rst         (rst_n),
    .i_init        (w_init),
    .i_k_ind_start (k_ind_start),
    .i_k_count     (k_count),
    .i_advance     (w_accept),
    .o_bank        (w_bank),
    .o_addr        (w_addr),
    .o_last        (w_last)
  );

  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_ready     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_init      = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_valid && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = w_valid & w_ready;

  // Address and data hold their last value between writes; only wr_en qualifies them
  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept ? bank_onehot(w_bank) : '0;
      if (w_accept) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_k3_weight_loader.sv
// Randomized self-checking bench for k3_weight_loader against a stream-index reference model.
module tb_k3_weight_loader;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  k_ind_start;
  logic [6:0]  k_count;
  logic        w_valid;
  logic [15:0] w_data;
  logic        w_ready;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic [35:0] wr_en;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  logic [15:0] img [36][36];

  k3_weight_loader dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .start       (start),
    .k_ind_start (k_ind_start),
    .k_count     (k_count),
    .w_valid     (w_valid),
    .w_data      (w_data),
    .w_ready     (w_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_in = ~clk_in;

  // gap: 0 none, 1 every third cycle idle, 2 random. Returns at posedge+1 with DUT idle.
  task automatic run_load(input int ks, input int kc, input int gap, input bit seq_data,
                          input int busy_start_at, input int rst_at,
                          output int n_wr, output int n_done, output int first_addr,
                          output int first_bank, output int last_addr, output int last_bank);
    int total, n, pb, pa, limit, bk;
    bit loading, done_m, pend, v, finished, aborted;
    logic [15:0] pd;
    logic [35:0] exp_en;
    total = 1296 * (kc + 1);
    limit = total * 2 + 50;
    n = 0; n_wr = 0; n_done = 0;
    first_addr = -1; first_bank = -1; last_addr = -1; last_bank = -1;
    pend = 0; pb = 0; pa = 0; pd = '0;
    finished = 0; aborted = 0;
    start = 1'b1; k_ind_start = 7'(ks); k_count = 7'(kc);
    w_valid = 1'b1; w_data = 16'hdead;
    @(posedge clk_in); #1;
    start = 1'b0; k_ind_start = '0; k_count = '0;
    loading = 1; done_m = 0;
    for (int cyc = 0; cyc < limit; cyc++) begin
      exp_en = '0;
      if (pend) exp_en[pb] = 1'b1;
      checks++;
      if (wr_en !== exp_en) begin
        failures++;
        $display("FAIL wr_en cyc=%0d got=%h exp=%h", cyc, wr_en, exp_en);
      end
      if (pend) begin
        checks++;
        if (wr_addr !== 13'(pa) || wr_data !== pd) begin
          failures++;
          $display("FAIL wr_addr_data cyc=%0d got=%0d/%h exp=%0d/%h", cyc, wr_addr, wr_data, pa, pd);
        end
      end
      checks++;
      if ({busy, w_ready, done} !== {loading, loading, done_m}) begin
        failures++;
        $display("FAIL busy_ready_done cyc=%0d got=%b%b%b exp=%b%b%b", cyc,
                 busy, w_ready, done, loading, loading, done_m);
      end
      if (wr_en != '0) begin
        bk = -1;
        for (int b = 0; b < 36; b++) if (wr_en[b]) bk = b;
        n_wr++;
        if (first_addr < 0) begin first_addr = int'(wr_addr); first_bank = bk; end
        last_addr = int'(wr_addr); last_bank = bk;
        if (wr_addr < 13'd36 && bk >= 0) img[bk][wr_addr] = wr_data;
      end
      if (done) n_done++;
      if (done_m) begin finished = 1; break; end
      if (rst_at >= 0 && n == rst_at) begin
        rst_n = 1'b1; w_valid = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (wr_en !== '0 || busy !== 1'b0 || w_ready !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL reset_midload got en=%h busy=%b ready=%b done=%b exp all 0",
                   wr_en, busy, w_ready, done);
        end
        rst_n = 1'b0;
        aborted = 1;
        break;
      end
      case (gap)
        1:       v = (cyc % 3) != 2;
        2:       v = $urandom_range(0, 3) != 0;
        default: v = 1;
      endcase
      w_valid = v;
      w_data = seq_data ? 16'(n) : 16'($urandom);
      start = (cyc == busy_start_at);
      k_ind_start = start ? 7'd5 : 7'd0;
      pend = v && loading;
      if (pend) begin
        pb = n % 36;
        pa = ((ks + n / 1296) * 36 + (n / 36) % 36) % 8192;
        pd = w_data;
        n++;
        if (n == total) begin loading = 0; done_m = 1; end
      end
      @(posedge clk_in); #1;
    end
    start = 1'b0; k_ind_start = '0;
    if (!finished && !aborted) begin
      checks++; failures++;
      $display("FAIL timeout ks=%0d kc=%0d words=%0d of %0d", ks, kc, n, total);
    end
    if (finished) begin
      @(posedge clk_in); #1;
      checks++;
      if (wr_en !== '0 || busy !== 1'b0 || done !== 1'b0 || w_ready !== 1'b0) begin
        failures++;
        $display("FAIL post_done got en=%h busy=%b done=%b ready=%b exp 0", wr_en, busy, done, w_ready);
      end
    end
    w_valid = 1'b0;
  endtask

  task automatic clear_img();
    for (int b = 0; b < 36; b++)
      for (int o = 0; o < 36; o++) img[b][o] = 16'hffff;
  endtask

  task automatic check_img(input string tag);
    for (int b = 0; b < 36; b++)
      for (int o = 0; o < 36; o++) begin
        checks++;
        if (img[b][o] !== 16'(o * 36 + b)) begin
          failures++;
          $display("FAIL %s img bank=%0d addr=%0d got=%0d exp=%0d", tag, b, o, img[b][o], o * 36 + b);
        end
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 0; k_ind_start = 0; k_count = 0; w_valid = 0; w_data = 0;
    #12;
    checks++;
    if (wr_en !== '0 || wr_addr !== '0 || wr_data !== '0 || w_ready !== 0 || busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL reset_state en=%h addr=%0d data=%h ready=%b busy=%b done=%b exp all 0",
               wr_en, wr_addr, wr_data, w_ready, busy, done);
    end
    @(posedge clk_in); #1;
    rst_n = 1'b0;
    w_valid = 1'b1; w_data = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in); #1;
      checks++;
      if (wr_en !== '0 || w_ready !== 0 || busy !== 0) begin
        failures++;
        $display("FAIL idle_no_accept en=%h ready=%b busy=%b exp 0", wr_en, w_ready, busy);
      end
    end
    w_valid = 1'b0;
  endtask

  task automatic test_single();
    int nw, nd, fa, fb, la, lb;
    clear_img();
    run_load(0, 0, 0, 1, -1, -1, nw, nd, fa, fb, la, lb);
    checks++;
    if (nw !== 1296 || nd !== 1) begin
      failures++; $display("FAIL single_counts writes=%0d dones=%0d exp 1296/1", nw, nd);
    end
    checks++;
    if (fa !== 0 || fb !== 0 || la !== 35 || lb !== 35) begin
      failures++; $display("FAIL single_ends first=%0d/%0d last=%0d/%0d exp 0/0 35/35", fa, fb, la, lb);
    end
    check_img("single");
  endtask

  task automatic test_offset();
    int nw, nd, fa, fb, la, lb;
    run_load(3, 1, 0, 0, -1, -1, nw, nd, fa, fb, la, lb);
    checks++;
    if (nw !== 2592 || nd !== 1) begin
      failures++; $display("FAIL offset_counts writes=%0d dones=%0d exp 2592/1", nw, nd);
    end
    checks++;
    if (fa !== 108 || fb !== 0 || la !== 179 || lb !== 35) begin
      failures++; $display("FAIL offset_ends first=%0d/%0d last=%0d/%0d exp 108/0 179/35", fa, fb, la, lb);
    end
  endtask

  task automatic test_backpressure();
    int nw, nd, fa, fb, la, lb;
    clear_img();
    run_load(0, 0, 1, 1, -1, -1, nw, nd, fa, fb, la, lb);
    checks++;
    if (nw !== 1296 || nd !== 1) begin
      failures++; $display("FAIL bp_counts writes=%0d dones=%0d exp 1296/1", nw, nd);
    end
    check_img("backpressure");
  endtask

  task automatic test_start_busy();
    int nw, nd, fa, fb, la, lb;
    run_load(0, 0, 2, 0, 400, -1, nw, nd, fa, fb, la, lb);
    checks++;
    if (nw !== 1296 || nd !== 1 || fa !== 0 || la !== 35 || lb !== 35) begin
      failures++;
      $display("FAIL start_busy writes=%0d dones=%0d first=%0d last=%0d/%0d exp 1296 1 0 35/35",
               nw, nd, fa, la, lb);
    end
  endtask

  task automatic test_reset_midload();
    int nw, nd, fa, fb, la, lb;
    run_load(0, 0, 2, 0, -1, 500, nw, nd, fa, fb, la, lb);
    checks++;
    if (nw !== 500 || nd !== 0) begin
      failures++; $display("FAIL midload_counts writes=%0d dones=%0d exp 500/0", nw, nd);
    end
    clear_img();
    run_load(0, 0, 0, 1, -1, -1, nw, nd, fa, fb, la, lb);
    checks++;
    if (nw !== 1296 || nd !== 1 || fa !== 0 || fb !== 0) begin
      failures++;
      $display("FAIL restart writes=%0d dones=%0d first=%0d/%0d exp 1296 1 0/0", nw, nd, fa, fb);
    end
    check_img("restart");
  endtask

  task automatic test_top_index();
    int nw, nd, fa, fb, la, lb;
    run_load(127, 0, 2, 0, -1, -1, nw, nd, fa, fb, la, lb);
    checks++;
    if (nw !== 1296 || nd !== 1 || fa !== 4572 || la !== 4607 || lb !== 35) begin
      failures++;
      $display("FAIL top_index writes=%0d dones=%0d first=%0d last=%0d/%0d exp 1296 1 4572 4607/35",
               nw, nd, fa, la, lb);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_offset();
    test_backpressure();
    test_start_busy();
    test_reset_midload();
    test_top_index();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
